// File: rtl/alu_share_arb.sv
// ---------------------------------------------------------------------------
// alu_share_arb
//   Time-shares one big_alu between two requesters (0: EX stage, 1: branch /
//   address unit). One operation is in flight at a time:
//     IDLE -> accept one request (round-robin on ties)
//     EXEC -> drive latched operands to the ALU for ALU_LAT cycles, then
//             sample result + flags
//     RESP -> hold the tagged response until the consumer takes it
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   reqN_valid/ready           request handshake, N = 0,1
//   reqN_a/b                   operands (WIDTH)
//   reqN_ctrl                  ALU op code, passed through unchanged
//   rsp_valid/ready            response handshake
//   rsp_id                     which requester owns the response
//   rsp_result/rsp_flags       sampled alu_result and {zero,carryout,overflow}
//   alu_in1/in2/ctrl           registered operand/op lines to big_alu
//   alu_result/zero/carryout/overflow   big_alu outputs
//   busy                       high whenever not IDLE
// ---------------------------------------------------------------------------
module alu_share_arb #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_ctrl,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [2:0]       rsp_flags,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carryout,
  input  logic             alu_overflow,
  output logic             busy
);

  if (ALU_LAT < 1) begin : g_lat_chk
    $error("alu_share_arb: ALU_LAT must be >= 1");
  end

  // Counter must hold ALU_LAT; never narrower than one bit.
  localparam int CW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       ctrl;
  } op_t;

  state_t        state, state_nxt;
  logic          last_grant;
  logic          grant;
  logic          accept;
  logic          sample;
  logic          op_id;
  logic [CW-1:0] cnt;
  op_t           sel_op;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // Next state, arbitration and handshake outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    sample     = 1'b0;

    // Lone requester wins; on a tie the one not served last time wins.
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant;

    sel_op.a    = grant ? req1_a    : req0_a;
    sel_op.b    = grant ? req1_b    : req0_b;
    sel_op.ctrl = grant ? req1_ctrl : req0_ctrl;

    case (state)
      IDLE: begin
        busy       = 1'b0;
        req0_ready = req0_valid & ~grant;
        req1_ready = req1_valid &  grant;
        accept     = req0_ready | req1_ready;
        if (accept) state_nxt = EXEC;
      end
      EXEC: begin
        // cnt was loaded with ALU_LAT at accept, so cnt==1 marks the
        // ALU_LAT-th edge after launch.
        if (cnt == CW'(1)) begin
          sample    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Operand / response datapath
  //   ALU lines only change on accept, so they stay quiet in IDLE and RESP.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_ctrl   <= 3'd0;
      op_id      <= 1'b0;
      cnt        <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= 3'd0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        alu_in1  <= sel_op.a;
        alu_in2  <= sel_op.b;
        alu_ctrl <= sel_op.ctrl;
        op_id    <= grant;
        cnt      <= CW'(ALU_LAT);
      end else if (state == EXEC) begin
        cnt <= cnt - CW'(1);
      end

      if (sample) begin
        rsp_result <= alu_result;
        rsp_flags  <= {alu_zero, alu_carryout, alu_overflow};
        rsp_id     <= op_id;
      end

      if (state == RESP && rsp_ready) last_grant <= rsp_id;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arb
//   Two instances side by side: u0 with ALU_LAT=1 and u1 with ALU_LAT=3.
//   Each has a behavioural big_alu stub (combinational op plus ALU_LAT-1
//   output register stages, so a too-early sample picks up stale data).
//   A transaction-level reference model predicts, per cycle, which
//   requester is granted, when the response appears and what it holds.
// ---------------------------------------------------------------------------
module tb_alu_share_arb;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n [2];
  logic           r0v [2], r0r [2], r1v [2], r1r [2];
  logic [W-1:0]   r0a [2], r0b [2], r1a [2], r1b [2];
  logic [2:0]     r0c [2], r1c [2];
  logic           rv [2], rr [2], rid [2], busy [2];
  logic [W-1:0]   rres [2];
  logic [2:0]     rflg [2];
  logic [W-1:0]   in1 [2], in2 [2], ares [2];
  logic [2:0]     actl [2];
  logic           az [2], ac [2], ao [2];

  int vectors = 0;
  int miscompares = 0;

  // Reference ALU: {zero, carryout, overflow, result}
  function automatic logic [W+2:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
    longint ua, ub, sa, sb, s, smax, smin;
    logic [W-1:0] r;
    logic c, v;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (op)
      3'd0: begin r = a + b; c = ((ua + ub) >> W) != 0; s = sa + sb; v = (s > smax) || (s < smin); end
      3'd1: begin r = a - b; c = (ua >= ub);            s = sa - sb; v = (s > smax) || (s < smin); end
      3'd2: r = a ^ b;
      3'd3: r[0] = (sa < sb);
      3'd4: r = a & b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      default: r = a | b;
    endcase
    return {(r == '0), c, v, r};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_u
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [W+2:0] comb_o, out_o;

    alu_share_arb #(.WIDTH(W), .ALU_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n[g]),
      .req0_valid(r0v[g]), .req0_ready(r0r[g]), .req0_a(r0a[g]), .req0_b(r0b[g]), .req0_ctrl(r0c[g]),
      .req1_valid(r1v[g]), .req1_ready(r1r[g]), .req1_a(r1a[g]), .req1_b(r1b[g]), .req1_ctrl(r1c[g]),
      .rsp_valid(rv[g]), .rsp_ready(rr[g]), .rsp_id(rid[g]), .rsp_result(rres[g]), .rsp_flags(rflg[g]),
      .alu_in1(in1[g]), .alu_in2(in2[g]), .alu_ctrl(actl[g]),
      .alu_result(ares[g]), .alu_zero(az[g]), .alu_carryout(ac[g]), .alu_overflow(ao[g]),
      .busy(busy[g])
    );

    assign comb_o = ref_alu(in1[g], in2[g], actl[g]);
    if (LAT == 1) begin : g_c
      assign out_o = comb_o;
    end else begin : g_p
      logic [LAT-2:0][W+2:0] sr;
      always @(posedge clk) begin
        sr[0] <= comb_o;
        for (int k = 1; k < LAT - 1; k++) sr[k] <= sr[k-1];
      end
      assign out_o = sr[LAT-2];
    end
    assign {az[g], ac[g], ao[g], ares[g]} = out_o;
  end

  // ---------------- reference model state ----------------
  bit           m_busy [2], m_last [2], m_id [2], acc0 [2], acc1 [2];
  int           m_rsp_at [2], cyc [2];
  logic [W-1:0] m_res [2], m_in1 [2], m_in2 [2];
  logic [2:0]   m_flg [2], m_ctl [2];
  bit           log_on = 1'b0;
  int           grant_log [$];

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h1;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic chk(input int u, input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL u%0d %s observed=%0h expected=%0h", u, tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int u);
    m_busy[u] = 0; m_last[u] = 1; m_id[u] = 0; acc0[u] = 0; acc1[u] = 0;
    m_res[u] = '0; m_flg[u] = '0; m_in1[u] = '0; m_in2[u] = '0; m_ctl[u] = '0;
    m_rsp_at[u] = 0;
  endtask

  task automatic set_req(input int u, input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] c);
    if (n == 0) begin r0v[u] = 1; r0a[u] = a; r0b[u] = b; r0c[u] = c; end
    else        begin r1v[u] = 1; r1a[u] = a; r1b[u] = b; r1c[u] = c; end
  endtask

  task automatic rnd_req(input int u, input int n);
    set_req(u, n, rnd_val(), rnd_val(), 3'($urandom_range(0, 7)));
  endtask

  // One cycle: inputs are already set (just after a negedge); check outputs
  // against the model, advance the model over the coming posedge.
  task automatic step(input int u);
    bit g, e0, e1, vis;
    #1;
    g  = (r0v[u] && r1v[u]) ? !m_last[u] : r1v[u];
    e0 = !m_busy[u] && r0v[u] && !g;
    e1 = !m_busy[u] && r1v[u] && g;
    vis = m_busy[u] && (cyc[u] >= m_rsp_at[u]);
    chk(u, "req0_ready", 64'(r0r[u]), 64'(e0));
    chk(u, "req1_ready", 64'(r1r[u]), 64'(e1));
    chk(u, "busy", 64'(busy[u]), 64'(m_busy[u]));
    chk(u, "rsp_valid", 64'(rv[u]), 64'(vis));
    chk(u, "alu_in1", 64'(in1[u]), 64'(m_in1[u]));
    chk(u, "alu_in2", 64'(in2[u]), 64'(m_in2[u]));
    chk(u, "alu_ctrl", 64'(actl[u]), 64'(m_ctl[u]));
    if (vis) begin
      chk(u, "rsp_id", 64'(rid[u]), 64'(m_id[u]));
      chk(u, "rsp_result", 64'(rres[u]), 64'(m_res[u]));
      chk(u, "rsp_flags", 64'(rflg[u]), 64'(m_flg[u]));
    end
    if (log_on && (r0r[u] || r1r[u])) grant_log.push_back(int'(r1r[u]));
    if (e0 || e1) begin
      m_busy[u]   = 1;
      m_rsp_at[u] = cyc[u] + 1 + lat_of(u);
      m_id[u]     = e1;
      m_in1[u]    = e1 ? r1a[u] : r0a[u];
      m_in2[u]    = e1 ? r1b[u] : r0b[u];
      m_ctl[u]    = e1 ? r1c[u] : r0c[u];
      {m_flg[u], m_res[u]} = ref_alu(m_in1[u], m_in2[u], m_ctl[u]);
    end else if (vis && rr[u]) begin
      m_busy[u] = 0;
      m_last[u] = m_id[u];
    end
    acc0[u] = e0;
    acc1[u] = e1;
    cyc[u]++;
    @(negedge clk);
    if (acc0[u]) r0v[u] = 0;
    if (acc1[u]) r1v[u] = 0;
  endtask

  // Let pending requests complete, then one idle cycle (bounded).
  task automatic drain(input int u);
    rr[u] = 1;
    for (int i = 0; i < 40; i++) begin
      if (!m_busy[u] && !r0v[u] && !r1v[u]) break;
      step(u);
    end
    step(u);
  endtask

  task automatic chk_zero(input int u, input string tag);
    chk(u, {tag, "_r0rdy"}, 64'(r0r[u]), 64'(0));
    chk(u, {tag, "_r1rdy"}, 64'(r1r[u]), 64'(0));
    chk(u, {tag, "_rspv"}, 64'(rv[u]), 64'(0));
    chk(u, {tag, "_busy"}, 64'(busy[u]), 64'(0));
    chk(u, {tag, "_rspid"}, 64'(rid[u]), 64'(0));
    chk(u, {tag, "_res"}, 64'(rres[u]), 64'(0));
    chk(u, {tag, "_flg"}, 64'(rflg[u]), 64'(0));
    chk(u, {tag, "_in1"}, 64'(in1[u]), 64'(0));
    chk(u, {tag, "_in2"}, 64'(in2[u]), 64'(0));
    chk(u, {tag, "_ctl"}, 64'(actl[u]), 64'(0));
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 0; r0v[u] = 0; r1v[u] = 0; rr[u] = 0;
      r0a[u] = '0; r0b[u] = '0; r0c[u] = '0; r1a[u] = '0; r1b[u] = '0; r1c[u] = '0;
      cyc[u] = 0;
      model_reset(u);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_zero(0, "reset");
    chk_zero(1, "reset");
    @(negedge clk);
    rst_n[0] = 1; rst_n[1] = 1;

    // Simple add on the single-cycle instance: 5 + 7 from requester 0
    rr[0] = 1;
    set_req(0, 0, 32'd5, 32'd7, 3'd0);
    step(0);
    step(0);
    chk(0, "t2_rsp_valid", 64'(rv[0]), 64'(1));
    chk(0, "t2_result", 64'(rres[0]), 64'(12));
    chk(0, "t2_id", 64'(rid[0]), 64'(0));
    step(0);

    // Signed overflow from requester 1
    set_req(0, 1, 32'h7FFF_FFFF, 32'h1, 3'd0);
    step(0);
    step(0);
    chk(0, "t6_flags", 64'(rflg[0]), 64'(3'b001));
    chk(0, "t6_result", 64'(rres[0]), 64'(32'h8000_0000));
    chk(0, "t6_id", 64'(rid[0]), 64'(1));
    step(0);

    // Both requesters always valid: grants must alternate starting with 0
    log_on = 1;
    for (int i = 0; i < 16; i++) begin
      if (!r0v[0]) rnd_req(0, 0);
      if (!r1v[0]) rnd_req(0, 1);
      step(0);
    end
    log_on = 0;
    chk(0, "t3_grant_count_ge4", 64'(grant_log.size() >= 4), 64'(1));
    for (int i = 0; i < grant_log.size(); i++)
      chk(0, $sformatf("t3_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));
    drain(0);

    // Response back-pressure: hold RESP for 5 cycles with new requests waiting
    rr[0] = 0;
    rnd_req(0, 0);
    step(0);
    step(0);
    step(0);
    rnd_req(0, 0);
    rnd_req(0, 1);
    for (int i = 0; i < 5; i++) step(0);
    chk(0, "t4_busy_held", 64'(busy[0]), 64'(1));
    rr[0] = 1;
    step(0);
    drain(0);

    // Three-cycle latency instance
    rr[1] = 1;
    rnd_req(1, 1);
    for (int i = 0; i < 7; i++) step(1);
    rnd_req(1, 0);
    for (int i = 0; i < 7; i++) step(1);
    drain(1);

    // Reset in the middle of EXEC drops the operation
    set_req(1, 0, 32'h1234_5678, 32'h0F0F_0F0F, 3'd2);
    step(1);
    step(1);
    rst_n[1] = 0;
    r0v[1] = 0;
    r1v[1] = 0;
    #1;
    chk_zero(1, "t1_midexec");
    model_reset(1);
    @(negedge clk);
    rst_n[1] = 1;
    for (int i = 0; i < 6; i++) step(1);

    // Random traffic on both latencies
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 400; i++) begin
        if (!r0v[u] && $urandom_range(0, 99) < 45) rnd_req(u, 0);
        if (!r1v[u] && $urandom_range(0, 99) < 45) rnd_req(u, 1);
        rr[u] = ($urandom_range(0, 99) < 60);
        step(u);
      end
      drain(u);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
